// File: rtl/axi_req_sched_pkg.sv
// Shared types for the AXI request scheduler: the write-buffer entry and the
// line-address slice used for hazard compares.
package axi_req_sched_pkg;

   localparam int LINE_HI = 31;
   localparam int LINE_LO = 4;
   localparam int LINE_W  = LINE_HI - LINE_LO + 1;

   typedef struct packed {
      logic [2:0]   wtype;
      logic [31:0]  addr;
      logic [3:0]   wstrb;
      logic [127:0] data;
   } wr_entry_t;

   typedef enum logic [1:0] {
      LOCK_NONE = 2'd0,
      LOCK_IC   = 2'd1,
      LOCK_DC   = 2'd2
   } lock_e;

endpackage

// File: rtl/axi_req_sched_wb_fifo.sv
// Circular write buffer for DCache line writebacks, with a per-entry line
// address compare so reads can detect pending writes to the same line.
module axi_req_sched_wb_fifo
   import axi_req_sched_pkg::*;
#(
   parameter int DEPTH = 2
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              push_i,
   input  wr_entry_t         push_entry_i,
   input  logic              pop_i,
   output wr_entry_t         head_o,
   output logic              full_o,
   output logic              empty_o,
   input  logic [LINE_W-1:0] cmp_line_i,
   output logic [DEPTH-1:0]  match_o
);

   localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   logic [PW-1:0]    wr_ptr_q;
   logic [PW-1:0]    rd_ptr_q;
   logic [CW-1:0]    count_q;
   logic [DEPTH-1:0] valid_q;
   wr_entry_t        mem_q [DEPTH];

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
         valid_q  <= '0;
      end else begin
         if (push_i) begin
            wr_ptr_q          <= wr_ptr_q + PW'(1);
            valid_q[wr_ptr_q] <= 1'b1;
         end
         if (pop_i) begin
            rd_ptr_q          <= rd_ptr_q + PW'(1);
            valid_q[rd_ptr_q] <= 1'b0;
         end
         if (push_i && !pop_i) begin
            count_q <= count_q + CW'(1);
         end else if (!push_i && pop_i) begin
            count_q <= count_q - CW'(1);
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (push_i) begin
         mem_q[wr_ptr_q] <= push_entry_i;
      end
   end

   assign head_o  = mem_q[rd_ptr_q];
   assign full_o  = (count_q == CW'(DEPTH));
   assign empty_o = (count_q == '0);

   always_comb begin
      match_o = '0;
      for (int i = 0; i < DEPTH; i++) begin
         match_o[i] = valid_q[i] && (mem_q[i].addr[LINE_HI:LINE_LO] == cmp_line_i);
      end
   end

endmodule

// File: rtl/axi_req_sched.sv
// Scheduler between the cache miss ports and the AXI bridge: buffers writebacks,
// arbitrates reads with bounded starvation, caps outstanding reads, blocks RAW hazards.
module axi_req_sched
   import axi_req_sched_pkg::*;
#(
   parameter int WB_DEPTH   = 2,
   parameter int STARVE_MAX = 4,
   parameter int MAX_RD_OUT = 2
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         icache_rd_req,
   input  logic [2:0]   icache_rd_type,
   input  logic [31:0]  icache_rd_addr,
   output logic         icache_rd_rdy,
   input  logic         dcache_rd_req,
   input  logic [2:0]   dcache_rd_type,
   input  logic [31:0]  dcache_rd_addr,
   output logic         dcache_rd_rdy,
   input  logic         dcache_wr_req,
   input  logic [2:0]   dcache_wr_type,
   input  logic [31:0]  dcache_wr_addr,
   input  logic [3:0]   dcache_wr_wstrb,
   input  logic [127:0] dcache_wr_data,
   output logic         dcache_wr_rdy,
   output logic         br_icache_rd_req,
   output logic [2:0]   br_icache_rd_type,
   output logic [31:0]  br_icache_rd_addr,
   input  logic         br_icache_rd_rdy,
   output logic         br_dcache_rd_req,
   output logic [2:0]   br_dcache_rd_type,
   output logic [31:0]  br_dcache_rd_addr,
   input  logic         br_dcache_rd_rdy,
   input  logic         br_icache_ret_last,
   input  logic         br_dcache_ret_last,
   output logic         br_dcache_wr_req,
   output logic [2:0]   br_dcache_wr_type,
   output logic [31:0]  br_dcache_wr_addr,
   output logic [3:0]   br_dcache_wr_wstrb,
   output logic [127:0] br_dcache_wr_data,
   input  logic         br_dcache_wr_rdy
);

   localparam int RW = $clog2(MAX_RD_OUT + 1);
   localparam int SW = $clog2(STARVE_MAX + 1);
   localparam logic [RW-1:0] RD_MAX = RW'(MAX_RD_OUT);
   localparam logic [SW-1:0] ST_MAX = SW'(STARVE_MAX);

   wr_entry_t         push_entry, head, head_out;
   logic              wb_full, wb_empty, push, pop, wr_req_int;
   logic [WB_DEPTH-1:0] wb_match;
   logic              inflight_q;
   logic [LINE_W-1:0] inflight_line_q;
   logic [SW-1:0]     starve_q, starve_d;
   logic [RW-1:0]     rd_out_q, rd_out_d;
   lock_e             lock_q, lock_d;
   logic              dcache_hz, rd_room, ic_elig, dc_elig;
   logic              gnt_ic, gnt_dc, ic_hs, dc_hs, ret_any;

   assign push_entry = '{wtype: dcache_wr_type, addr: dcache_wr_addr,
                         wstrb: dcache_wr_wstrb, data: dcache_wr_data};
   assign push       = dcache_wr_req & ~wb_full;
   assign wr_req_int = ~wb_empty & ~inflight_q;
   assign pop        = wr_req_int & br_dcache_wr_rdy;

   axi_req_sched_wb_fifo #(.DEPTH(WB_DEPTH)) u_wb_fifo (
      .clk_i        (aclk),
      .rst_ni       (aresetn),
      .push_i       (push),
      .push_entry_i (push_entry),
      .pop_i        (pop),
      .head_o       (head),
      .full_o       (wb_full),
      .empty_o      (wb_empty),
      .cmp_line_i   (dcache_rd_addr[LINE_HI:LINE_LO]),
      .match_o      (wb_match)
   );

   assign dcache_hz = dcache_rd_req & ((|wb_match) |
                      (inflight_q & (inflight_line_q == dcache_rd_addr[LINE_HI:LINE_LO])));
   assign rd_room   = (rd_out_q < RD_MAX);
   assign ic_elig   = icache_rd_req & rd_room;
   assign dc_elig   = dcache_rd_req & rd_room & ~dcache_hz;

   // A locked grant is held until accepted; otherwise DCache wins unless ICache has starved.
   always_comb begin
      gnt_ic = 1'b0;
      gnt_dc = 1'b0;
      if (lock_q == LOCK_IC) begin
         gnt_ic = 1'b1;
      end else if (lock_q == LOCK_DC) begin
         gnt_dc = 1'b1;
      end else if (dc_elig && !(ic_elig && (starve_q == ST_MAX))) begin
         gnt_dc = 1'b1;
      end else begin
         gnt_ic = ic_elig;
      end
   end

   assign ic_hs   = gnt_ic & br_icache_rd_rdy;
   assign dc_hs   = gnt_dc & br_dcache_rd_rdy;
   assign ret_any = br_icache_ret_last | br_dcache_ret_last;

   always_comb begin
      lock_d = LOCK_NONE;
      if (gnt_ic && !br_icache_rd_rdy) begin
         lock_d = LOCK_IC;
      end else if (gnt_dc && !br_dcache_rd_rdy) begin
         lock_d = LOCK_DC;
      end

      starve_d = starve_q;
      if (!icache_rd_req || ic_hs) begin
         starve_d = '0;
      end else if (dc_hs && (starve_q != ST_MAX)) begin
         starve_d = starve_q + SW'(1);
      end

      rd_out_d = rd_out_q;
      if ((ic_hs || dc_hs) && !ret_any) begin
         rd_out_d = rd_out_q + RW'(1);
      end else if (!(ic_hs || dc_hs) && ret_any && (rd_out_q != '0)) begin
         rd_out_d = rd_out_q - RW'(1);
      end
   end

   // Inflight covers the write between its pop and the next idle cycle of the bridge write port.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         inflight_q      <= 1'b0;
         inflight_line_q <= '0;
         starve_q        <= '0;
         rd_out_q        <= '0;
         lock_q          <= LOCK_NONE;
      end else begin
         if (pop) begin
            inflight_q      <= 1'b1;
            inflight_line_q <= head.addr[LINE_HI:LINE_LO];
         end else if (inflight_q && br_dcache_wr_rdy) begin
            inflight_q <= 1'b0;
         end
         starve_q <= starve_d;
         rd_out_q <= rd_out_d;
         lock_q   <= lock_d;
      end
   end

   assign head_out           = aresetn ? head : '0;
   assign dcache_wr_rdy      = aresetn & ~wb_full;
   assign br_dcache_wr_req   = aresetn & wr_req_int;
   assign br_dcache_wr_type  = head_out.wtype;
   assign br_dcache_wr_addr  = head_out.addr;
   assign br_dcache_wr_wstrb = head_out.wstrb;
   assign br_dcache_wr_data  = head_out.data;

   assign br_icache_rd_req  = aresetn & gnt_ic;
   assign br_dcache_rd_req  = aresetn & gnt_dc;
   assign icache_rd_rdy     = aresetn & ic_hs;
   assign dcache_rd_rdy     = aresetn & dc_hs;
   assign br_icache_rd_type = aresetn ? icache_rd_type : '0;
   assign br_icache_rd_addr = aresetn ? icache_rd_addr : '0;
   assign br_dcache_rd_type = aresetn ? dcache_rd_type : '0;
   assign br_dcache_rd_addr = aresetn ? dcache_rd_addr : '0;

endmodule

// File: tb/tb_axi_req_sched.sv
// Self-checking bench for axi_req_sched: directed scenarios followed by random
// traffic, all compared against a queue-based reference model.
module tb_axi_req_sched;

   localparam int WB_DEPTH   = 2;
   localparam int STARVE_MAX = 4;
   localparam int MAX_RD_OUT = 2;

   logic         aclk = 1'b0;
   logic         aresetn = 1'b0;
   logic         icache_rd_req = 1'b0, dcache_rd_req = 1'b0, dcache_wr_req = 1'b0;
   logic [2:0]   icache_rd_type = '0, dcache_rd_type = '0, dcache_wr_type = '0;
   logic [31:0]  icache_rd_addr = '0, dcache_rd_addr = '0, dcache_wr_addr = '0;
   logic [3:0]   dcache_wr_wstrb = '0;
   logic [127:0] dcache_wr_data = '0;
   logic         br_icache_rd_rdy = 1'b0, br_dcache_rd_rdy = 1'b0, br_dcache_wr_rdy = 1'b0;
   logic         br_icache_ret_last = 1'b0, br_dcache_ret_last = 1'b0;
   logic         icache_rd_rdy, dcache_rd_rdy, dcache_wr_rdy;
   logic         br_icache_rd_req, br_dcache_rd_req, br_dcache_wr_req;
   logic [2:0]   br_icache_rd_type, br_dcache_rd_type, br_dcache_wr_type;
   logic [31:0]  br_icache_rd_addr, br_dcache_rd_addr, br_dcache_wr_addr;
   logic [3:0]   br_dcache_wr_wstrb;
   logic [127:0] br_dcache_wr_data;

   axi_req_sched #(.WB_DEPTH(WB_DEPTH), .STARVE_MAX(STARVE_MAX), .MAX_RD_OUT(MAX_RD_OUT)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .icache_rd_req(icache_rd_req), .icache_rd_type(icache_rd_type),
      .icache_rd_addr(icache_rd_addr), .icache_rd_rdy(icache_rd_rdy),
      .dcache_rd_req(dcache_rd_req), .dcache_rd_type(dcache_rd_type),
      .dcache_rd_addr(dcache_rd_addr), .dcache_rd_rdy(dcache_rd_rdy),
      .dcache_wr_req(dcache_wr_req), .dcache_wr_type(dcache_wr_type),
      .dcache_wr_addr(dcache_wr_addr), .dcache_wr_wstrb(dcache_wr_wstrb),
      .dcache_wr_data(dcache_wr_data), .dcache_wr_rdy(dcache_wr_rdy),
      .br_icache_rd_req(br_icache_rd_req), .br_icache_rd_type(br_icache_rd_type),
      .br_icache_rd_addr(br_icache_rd_addr), .br_icache_rd_rdy(br_icache_rd_rdy),
      .br_dcache_rd_req(br_dcache_rd_req), .br_dcache_rd_type(br_dcache_rd_type),
      .br_dcache_rd_addr(br_dcache_rd_addr), .br_dcache_rd_rdy(br_dcache_rd_rdy),
      .br_icache_ret_last(br_icache_ret_last), .br_dcache_ret_last(br_dcache_ret_last),
      .br_dcache_wr_req(br_dcache_wr_req), .br_dcache_wr_type(br_dcache_wr_type),
      .br_dcache_wr_addr(br_dcache_wr_addr), .br_dcache_wr_wstrb(br_dcache_wr_wstrb),
      .br_dcache_wr_data(br_dcache_wr_data), .br_dcache_wr_rdy(br_dcache_wr_rdy)
   );

   always #5 aclk = ~aclk;

   int errors = 0;
   int checks = 0;

   task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Reference model: the write buffer as a queue, plus read bookkeeping as plain integers.
   typedef struct packed {
      logic [2:0]   t;
      logic [31:0]  a;
      logic [3:0]   s;
      logic [127:0] d;
   } went_t;

   went_t       wq[$];
   bit          infl = 0;
   logic [27:0] infl_line = '0;
   int          rdo = 0, st = 0, lock = 0;
   bit          m_hs_i, m_hs_d;
   bit          obs_ic_rdy, obs_dc_rdy, obs_br_dc_req, obs_bw_req;

   function automatic void modelReset();
      wq.delete();
      infl = 0; rdo = 0; st = 0; lock = 0;
   endfunction

   function automatic logic anyOut();
      return |{icache_rd_rdy, dcache_rd_rdy, dcache_wr_rdy, br_icache_rd_req, br_icache_rd_type,
               br_icache_rd_addr, br_dcache_rd_req, br_dcache_rd_type, br_dcache_rd_addr,
               br_dcache_wr_req, br_dcache_wr_type, br_dcache_wr_addr, br_dcache_wr_wstrb,
               br_dcache_wr_data};
   endfunction

   task automatic driveInputs(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                              input bit wr, input logic [31:0] wa, input bit bi, input bit bd,
                              input bit bw, input bit ri, input bit rd);
      icache_rd_req = ir; icache_rd_addr = ia; icache_rd_type = 3'($urandom);
      dcache_rd_req = dr; dcache_rd_addr = da; dcache_rd_type = 3'($urandom);
      dcache_wr_req = wr; dcache_wr_addr = wa; dcache_wr_type = 3'($urandom);
      dcache_wr_wstrb = 4'($urandom);
      dcache_wr_data = {$urandom, $urandom, $urandom, $urandom};
      br_icache_rd_rdy = bi; br_dcache_rd_rdy = bd; br_dcache_wr_rdy = bw;
      br_icache_ret_last = ri; br_dcache_ret_last = rd;
   endtask

   // One clock: check outputs at the falling edge, then advance the model at the rising edge.
   task automatic step();
      bit hz, ie, de, wrdy, bwreq, gi, gd, push;
      @(negedge aclk);
      wrdy  = wq.size() < WB_DEPTH;
      bwreq = (wq.size() > 0) && !infl;
      hz = 0;
      if (dcache_rd_req) begin
         foreach (wq[i]) if (wq[i].a[31:4] == dcache_rd_addr[31:4]) hz = 1;
         if (infl && infl_line == dcache_rd_addr[31:4]) hz = 1;
      end
      ie = icache_rd_req && (rdo < MAX_RD_OUT);
      de = dcache_rd_req && (rdo < MAX_RD_OUT) && !hz;
      gi = 0; gd = 0;
      if (lock == 1) gi = 1;
      else if (lock == 2) gd = 1;
      else if (de && !(ie && st == STARVE_MAX)) gd = 1;
      else if (ie) gi = 1;
      checkOutput("wr_rdy", dcache_wr_rdy, wrdy);
      checkOutput("br_wr_req", br_dcache_wr_req, bwreq);
      if (bwreq) begin
         checkOutput("br_wr_hdr", {br_dcache_wr_type, br_dcache_wr_wstrb, br_dcache_wr_addr},
                     {wq[0].t, wq[0].s, wq[0].a});
         checkOutput("br_wr_data", br_dcache_wr_data, wq[0].d);
      end
      checkOutput("br_ic_req", br_icache_rd_req, gi);
      checkOutput("br_dc_req", br_dcache_rd_req, gd);
      checkOutput("ic_rdy", icache_rd_rdy, gi && br_icache_rd_rdy);
      checkOutput("dc_rdy", dcache_rd_rdy, gd && br_dcache_rd_rdy);
      checkOutput("br_ic_fwd", {br_icache_rd_type, br_icache_rd_addr}, {icache_rd_type, icache_rd_addr});
      checkOutput("br_dc_fwd", {br_dcache_rd_type, br_dcache_rd_addr}, {dcache_rd_type, dcache_rd_addr});
      obs_ic_rdy = icache_rd_rdy; obs_dc_rdy = dcache_rd_rdy;
      obs_br_dc_req = br_dcache_rd_req; obs_bw_req = br_dcache_wr_req;
      m_hs_i = gi && br_icache_rd_rdy;
      m_hs_d = gd && br_dcache_rd_rdy;
      push = dcache_wr_req && wrdy;
      @(posedge aclk);
      if (bwreq && br_dcache_wr_rdy) begin
         infl_line = wq[0].a[31:4];
         void'(wq.pop_front());
         infl = 1;
      end else if (infl && br_dcache_wr_rdy) begin
         infl = 0;
      end
      if (push) wq.push_back('{dcache_wr_type, dcache_wr_addr, dcache_wr_wstrb, dcache_wr_data});
      if ((m_hs_i || m_hs_d) && !(br_icache_ret_last || br_dcache_ret_last)) rdo++;
      else if (!(m_hs_i || m_hs_d) && (br_icache_ret_last || br_dcache_ret_last) && rdo > 0) rdo--;
      if (!icache_rd_req || m_hs_i) st = 0;
      else if (m_hs_d && st < STARVE_MAX) st++;
      if (gi && !br_icache_rd_rdy) lock = 1;
      else if (gd && !br_dcache_rd_rdy) lock = 2;
      else lock = 0;
      #1;
   endtask

   task automatic applyStimulus(input bit ir, input logic [31:0] ia, input bit dr, input logic [31:0] da,
                                input bit wr, input logic [31:0] wa, input bit bi, input bit bd,
                                input bit bw, input bit ri, input bit rd);
      driveInputs(ir, ia, dr, da, wr, wa, bi, bd, bw, ri, rd);
      step();
   endtask

   initial begin
      #1000000;
      $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int waited;
      bit ir, dr, ri, rd;
      logic [31:0] ia, da;
      logic [31:0] pool [4];
      pool[0] = 32'h1000; pool[1] = 32'h1040; pool[2] = 32'h2000; pool[3] = 32'h2080;

      // Outputs must be zero while reset is held, regardless of inputs.
      driveInputs(1, 32'h100, 1, 32'h200, 1, 32'h300, 1, 1, 1, 0, 0);
      #22;
      checkOutput("rst_zero", anyOut(), 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;

      // Two writes: first drains the cycle after push, then a third fills the buffer.
      applyStimulus(0, 0, 0, 0, 1, 32'h1000, 0, 0, 1, 0, 0);
      checkOutput("wr_no_bypass", obs_bw_req, 0);
      applyStimulus(0, 0, 0, 0, 1, 32'h2000, 0, 0, 1, 0, 0);
      checkOutput("wr_latency", obs_bw_req, 1);
      applyStimulus(0, 0, 0, 0, 1, 32'h3000, 0, 0, 0, 0, 0);
      checkOutput("wr_full", dcache_wr_rdy, 0);
      checkOutput("wr_infl_hold", br_dcache_wr_req, 0);

      // Reset with two entries buffered and a write in flight.
      driveInputs(1, 32'h4000, 1, 32'h5000, 1, 32'h6000, 1, 1, 1, 1, 1);
      aresetn = 1'b0;
      #1;
      checkOutput("rst_mid_zero", anyOut(), 0);
      modelReset();
      @(posedge aclk); @(posedge aclk); #1;
      driveInputs(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
      aresetn = 1'b1;
      #1;
      checkOutput("post_rst_wr_rdy", dcache_wr_rdy, 1);
      checkOutput("post_rst_br_wr", br_dcache_wr_req, 0);
      step();

      // Hazard: buffered write to line 0x104 blocks 0x1048 but not 0x1050.
      applyStimulus(0, 0, 0, 0, 1, 32'h1040, 0, 0, 0, 0, 0);
      applyStimulus(0, 0, 1, 32'h1048, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("hz_block", obs_dc_rdy, 0);
      applyStimulus(0, 0, 1, 32'h1050, 0, 0, 0, 1, 0, 0, 0);
      checkOutput("hz_other_line", obs_dc_rdy, 1);
      waited = -1;
      for (int i = 0; i < 10; i++) begin
         applyStimulus(0, 0, 1, 32'h1048, 0, 0, 0, 1, 1, 0, 0);
         if (obs_dc_rdy) begin waited = i; break; end
      end
      checkOutput("hz_release_cycle", waited, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

      // Grant lock: ICache granted but not accepted keeps the grant against DCache.
      applyStimulus(1, 32'h4000, 0, 0, 0, 0, 0, 1, 1, 0, 0);
      applyStimulus(1, 32'h4000, 1, 32'h5000, 0, 0, 0, 1, 1, 0, 0);
      checkOutput("lock_hold", obs_br_dc_req, 0);
      applyStimulus(1, 32'h4000, 1, 32'h5000, 0, 0, 1, 1, 1, 0, 0);
      checkOutput("lock_accept", obs_ic_rdy, 1);
      applyStimulus(0, 0, 1, 32'h5000, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1);

      // Starvation: four DCache grants then one ICache grant, repeating.
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 32'h6000, 1, 32'h7000, 0, 0, 1, 1, 1, 0, i > 0);
         checkOutput("starve_seq", obs_ic_rdy, (i % 5) == 4);
      end
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0);

      // Outstanding cap: two accepted reads block a third; return plus accept keeps the count.
      applyStimulus(1, 32'h8000, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 32'h8010, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 32'h8020, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      checkOutput("cap_block", obs_ic_rdy, 0);
      applyStimulus(1, 32'h8020, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      applyStimulus(1, 32'h8020, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      checkOutput("cap_hs_and_ret", obs_ic_rdy, 1);
      applyStimulus(1, 32'h8030, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      applyStimulus(1, 32'h8040, 0, 0, 0, 0, 1, 1, 1, 0, 0);
      checkOutput("cap_block2", obs_ic_rdy, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 0);
      applyStimulus(0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 1);

      // Random traffic; read requests are held until accepted.
      ir = 0; dr = 0; ia = 0; da = 0;
      for (int c = 0; c < 3000; c++) begin
         if (!ir && ($urandom_range(0, 2) == 0)) begin
            ir = 1; ia = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
         end
         if (!dr && ($urandom_range(0, 2) == 0)) begin
            dr = 1; da = pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15));
         end
         ri = 0; rd = 0;
         if (rdo > 0 && ($urandom_range(0, 2) == 0)) begin
            if ($urandom_range(0, 1) == 0) ri = 1; else rd = 1;
         end
         applyStimulus(ir, ia, dr, da, $urandom_range(0, 2) == 0,
                       pool[$urandom_range(0, 3)] | 32'($urandom_range(0, 15)),
                       $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0,
                       $urandom_range(0, 2) != 0, ri, rd);
         if (m_hs_i) ir = 0;
         if (m_hs_d) dr = 0;
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
